rv_mc_ctrl: RTL and testbench

- Multi-cycle main control FSM that issues operations to the 64-bit ALU datapath.
- Accepts one 32-bit RV64 instruction per transaction over a valid/ready handshake and sequences DECODE, EXEC, MEM and WB.
- Produces the ALUOp and funct fields consumed by the ALU control unit, plus register-file, PC and memory strobes.
- Sits between the fetch stage and the ALU/register-file/data-memory datapath.

---
 rtl/rv_ctrl_pkg.sv | 37 +++
 rtl/rv_mc_ctrl_if.sv | 33 +++
 rtl/rv_mc_decode.sv | 24 ++
 rtl/rv_mc_ctrl.sv | 153 +++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared opcode, ALUOp, state and instruction-class definitions for the
// multi-cycle RV64 main control FSM.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [2:0] F3_BEQ   = 3'b000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [1:0] {
    CL_R,
    CL_LD,
    CL_SD,
    CL_BEQ
  } iclass_t;

  // Field handed to the ALU control unit: {funct7[5], funct3}.
  function automatic logic [3:0] alu_cs_of(input logic [31:0] ir);
    return {ir[30], ir[14:12]};
  endfunction

endpackage

// File: rtl/rv_mc_ctrl_if.sv
// Fetch / ALU / data-memory handshake bundle around the main control FSM.
interface rv_mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;
  logic             alu_zero;
  logic [1:0]       alu_op;
  logic [3:0]       alu_cs;
  logic             alu_src_imm;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ack;
  logic             reg_we;
  logic             pc_we;
  logic             pc_sel;
  logic             err;
  logic [CNT_W-1:0] retired;

  // master: the fetch/datapath side; slave: the controller.
  modport master (
    output instr_valid, instr, alu_zero, mem_ack,
    input  instr_ready, alu_op, alu_cs, alu_src_imm, mem_req, mem_we,
           reg_we, pc_we, pc_sel, err, retired
  );

  modport slave (
    input  instr_valid, instr, alu_zero, mem_ack,
    output instr_ready, alu_op, alu_cs, alu_src_imm, mem_req, mem_we,
           reg_we, pc_we, pc_sel, err, retired
  );
endinterface

// File: rtl/rv_mc_decode.sv
// Combinational opcode/funct3 classifier; anything outside R, LD, SD, BEQ
// is flagged illegal.
module rv_mc_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output iclass_t    cls,
  output logic       illegal
);

  always_comb begin
    cls     = CL_R;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls = CL_R;
      OP_LOAD:   begin cls = CL_LD;  illegal = (funct3 != F3_DWORD); end
      OP_STORE:  begin cls = CL_SD;  illegal = (funct3 != F3_DWORD); end
      OP_BRANCH: begin cls = CL_BEQ; illegal = (funct3 != F3_BEQ);   end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle main control FSM: accepts one instruction, then sequences
// DECODE, EXEC, MEM and WB, driving ALU, register-file, PC and memory strobes.
//
//   state  | meaning
//   IDLE   | instr_ready high, waiting for a fetch handshake
//   DECODE | classify latched instruction, err on illegal
//   EXEC   | ALU operation; BEQ resolves and retires here
//   MEM    | hold mem_req until mem_ack or timeout
//   WB     | register write + PC+4, retire
module rv_mc_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  rv_mc_ctrl_if.slave  bus
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state, state_nx;
  logic [31:0]      ir;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] retired;
  iclass_t          cls;
  logic             illegal;

  logic       ready, retire;
  logic [1:0] alu_op;
  logic [3:0] alu_cs;
  logic       alu_src_imm, mem_req, mem_we, reg_we, pc_we, pc_sel, err;

  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

  rv_mc_decode u_decode (
    .opcode  (ir[6:0]),
    .funct3  (ir[14:12]),
    .cls     (cls),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ir      <= '0;
      tmr     <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (ready && bus.instr_valid)
        ir <= bus.instr;
      // Timer is reloaded on the way into MEM and counts only ack-less cycles.
      if (state == ST_EXEC)
        tmr <= TMR_W'(MEM_TIMEOUT);
      else if (state == ST_MEM && !bus.mem_ack)
        tmr <= tmr - TMR_W'(1);
      if (retire)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx    = state;
    ready       = 1'b0;
    retire      = 1'b0;
    alu_op      = ALUOP_ADD;
    alu_cs      = 4'b0000;
    alu_src_imm = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    err         = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid)
          state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        if (illegal) begin
          err      = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_cs = alu_cs_of(ir);
        case (cls)
          CL_R: begin
            alu_op   = ALUOP_FUNCT;
            state_nx = ST_WB;
          end
          CL_LD, CL_SD: begin
            alu_op      = ALUOP_ADD;
            alu_src_imm = 1'b1;
            state_nx    = ST_MEM;
          end
          CL_BEQ: begin
            alu_op   = ALUOP_SUB;
            pc_we    = 1'b1;
            pc_sel   = bus.alu_zero;
            retire   = 1'b1;
            state_nx = ST_IDLE;
          end
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == CL_SD);
        // An ack on the terminal-count cycle still completes the access.
        if (bus.mem_ack) begin
          if (cls == CL_SD) begin
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WB;
          end
        end else if (tmr == TMR_W'(1)) begin
          err      = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_WB: begin
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        retire   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Gated so that every output reads 0 while reset is held.
  assign bus.instr_ready = ready && rst_n;
  assign bus.alu_op      = alu_op;
  assign bus.alu_cs      = alu_cs;
  assign bus.alu_src_imm = alu_src_imm;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.reg_we      = reg_we;
  assign bus.pc_we       = pc_we;
  assign bus.pc_sel      = pc_sel;
  assign bus.err         = err;
  assign bus.retired     = retired;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: a transaction-level model produces the
// expected output vector for every cycle; one negedge process compares.
module tb_rv_mc_ctrl;
  localparam int CNT_W = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  rv_mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic             ready;
    logic [1:0]       alu_op;
    logic [3:0]       alu_cs;
    logic             src;
    logic             mem_req;
    logic             mem_we;
    logic             reg_we;
    logic             pc_we;
    logic             pc_sel;
    logic             err;
    logic [CNT_W-1:0] retired;
  } vec_t;

  typedef enum {K_R, K_LD, K_SD, K_BEQ, K_ILL} kind_t;

  vec_t        want;
  logic        want_valid = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int unsigned model_retired = 0;
  int          mreq_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_req) mreq_cnt++;
    if (want_valid) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(want.ready));
      chk("alu_op",      32'(bus.alu_op),      32'(want.alu_op));
      chk("alu_cs",      32'(bus.alu_cs),      32'(want.alu_cs));
      chk("alu_src_imm", 32'(bus.alu_src_imm), 32'(want.src));
      chk("mem_req",     32'(bus.mem_req),     32'(want.mem_req));
      chk("mem_we",      32'(bus.mem_we),      32'(want.mem_we));
      chk("reg_we",      32'(bus.reg_we),      32'(want.reg_we));
      chk("pc_we",       32'(bus.pc_we),       32'(want.pc_we));
      chk("pc_sel",      32'(bus.pc_sel),      32'(want.pc_sel));
      chk("err",         32'(bus.err),         32'(want.err));
      chk("retired",     32'(bus.retired),     32'(want.retired));
    end
  end

  function automatic kind_t kind_of(input logic [31:0] w);
    if (w[6:0] == 7'h33) return K_R;
    if (w[6:0] == 7'h03 && w[14:12] == 3'd3) return K_LD;
    if (w[6:0] == 7'h23 && w[14:12] == 3'd3) return K_SD;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd0) return K_BEQ;
    return K_ILL;
  endfunction

  function automatic logic [3:0] cs_of(input logic [31:0] w);
    return {w[30], w[14:12]};
  endfunction

  function automatic vec_t base(input logic rdy);
    vec_t v;
    v = '0;
    v.ready = rdy;
    v.retired = model_retired[CNT_W-1:0];
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [4];
    int          sel;
    ops = '{7'h33, 7'h03, 7'h23, 7'h63};
    w   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1: w[6:0] = 7'h33;
      2, 3: begin w[6:0] = 7'h03; w[14:12] = 3'd3; end
      4, 5: begin w[6:0] = 7'h23; w[14:12] = 3'd3; end
      6, 7: begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
      8:    begin w[6:0] = ops[$urandom_range(0, 3)]; w[14:12] = 3'($urandom); end
      default: ;
    endcase
    return w;
  endfunction

  // Publish the expectation for the current cycle, then advance one clock.
  task automatic cyc(input vec_t v);
    want = v;
    want_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] w, input int gap, input int ack_at, input logic z);
    vec_t  v;
    kind_t k;
    k = kind_of(w);
    for (int i = 0; i < gap; i++) begin
      bus.instr_valid = 1'b0;
      bus.instr = $urandom;
      bus.mem_ack = 1'($urandom_range(0, 1));
      cyc(base(1'b1));
    end
    bus.instr_valid = 1'b1;
    bus.instr = w;
    bus.mem_ack = 1'b0;
    cyc(base(1'b1));
    // DECODE: fetch-side noise must be ignored
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.instr = $urandom;
    bus.mem_ack = 1'($urandom_range(0, 1));
    v = base(1'b0);
    if (k == K_ILL) begin
      v.err = 1'b1;
      cyc(v);
      bus.instr_valid = 1'b0;
      bus.mem_ack = 1'b0;
      return;
    end
    cyc(v);
    bus.alu_zero = z;
    bus.mem_ack = 1'($urandom_range(0, 1));
    v = base(1'b0);
    v.alu_cs = cs_of(w);
    case (k)
      K_R:     v.alu_op = 2'b10;
      K_BEQ:   begin v.alu_op = 2'b01; v.pc_we = 1'b1; v.pc_sel = z; end
      default: begin v.alu_op = 2'b00; v.src = 1'b1; end
    endcase
    cyc(v);
    bus.instr_valid = 1'b0;
    bus.alu_zero = 1'($urandom_range(0, 1));
    bus.mem_ack = 1'b0;
    if (k == K_BEQ) begin
      model_retired++;
      return;
    end
    if (k == K_LD || k == K_SD) begin
      for (int m = 1; m <= TMO; m++) begin
        bus.mem_ack = (m == ack_at);
        v = base(1'b0);
        v.mem_req = 1'b1;
        v.mem_we = (k == K_SD);
        if (m == ack_at) v.pc_we = (k == K_SD);
        else if (m == TMO) v.err = 1'b1;
        cyc(v);
        if (m == ack_at) break;
      end
      bus.mem_ack = 1'b0;
      if (ack_at > TMO) return;
      if (k == K_SD) begin
        model_retired++;
        return;
      end
    end
    v = base(1'b0);
    v.reg_we = 1'b1;
    v.pc_we = 1'b1;
    cyc(v);
    model_retired++;
  endtask

  task automatic reset_in_mem();
    vec_t v;
    bus.instr_valid = 1'b1;
    bus.instr = 32'h0080B283;
    cyc(base(1'b1));
    bus.instr_valid = 1'b0;
    cyc(base(1'b0));
    v = base(1'b0);
    v.src = 1'b1;
    v.alu_cs = 4'b0011;
    cyc(v);
    v = base(1'b0);
    v.mem_req = 1'b1;
    cyc(v);
    want = v;
    #2;
    rst_n = 1'b0;
    want = '0;
    #1;
    chk("rst_mem_req",     32'(bus.mem_req), 32'd0);
    chk("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_retired",     32'(bus.retired), 32'd0);
    @(posedge clk);
    #1;
    cyc('0);
    rst_n = 1'b1;
    model_retired = 0;
    cyc(base(1'b1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.alu_zero = 1'b0;
    bus.mem_ack = 1'b0;
    want = '0;
    want_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    chk("model_kind_add", 32'(kind_of(32'h002081B3)), 32'(K_R));
    chk("model_kind_ld",  32'(kind_of(32'h0080B283)), 32'(K_LD));
    chk("model_kind_beq", 32'(kind_of(32'h00208063)), 32'(K_BEQ));
    chk("model_kind_ill", 32'(kind_of(32'hFFFFFFFF)), 32'(K_ILL));
    chk("model_cs_sub",   32'(cs_of(32'h402081B3)),   32'h8);

    run_instr(32'h002081B3, 0, 0, 1'b0);
    chk("retired_after_add", 32'(bus.retired), 32'd1);
    run_instr(32'h402081B3, 1, 0, 1'b0);
    mreq_cnt = 0;
    run_instr(32'h0080B283, 0, 3, 1'b0);
    chk("ld_mem_req_cycles", 32'(mreq_cnt), 32'd3);
    run_instr(32'h00208063, 0, 0, 1'b1);
    run_instr(32'h00208063, 2, 0, 1'b0);
    chk("retired_after_beq", 32'(bus.retired), 32'd5);
    mreq_cnt = 0;
    run_instr(32'h0020B023, 0, 99, 1'b0);
    chk("sd_timeout_mem_req_cycles", 32'(mreq_cnt), 32'd16);
    chk("retired_after_timeout", 32'(bus.retired), 32'd5);
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0);
    run_instr(32'h0020B023, 0, TMO, 1'b0);
    chk("retired_ack_on_last", 32'(bus.retired), 32'd6);

    for (int n = 0; n < 300; n++)
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(1, 20),
                1'($urandom_range(0, 1)));

    reset_in_mem();
    run_instr(32'h002081B3, 0, 0, 1'b0);
    chk("retired_after_reset_add", 32'(bus.retired), 32'd1);

    want_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
